// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port between the pipeline M stage (core) and a
// debug/inspection requester (debug). The core has fixed priority. A wait
// counter bounds debug starvation: after MAX_WAIT consecutive denied debug
// cycles, the FSM forces exactly one debug access and stalls the core for
// that cycle.
//
// Parameters
//   XLEN      data / address width
//   MAX_WAIT  consecutive denied debug cycles before a forced debug grant (>=1)
//   CNT_W     width of the conflict counter
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_req_i/we_i     M-stage access valid / write enable
//   core_addr_i/wdata_i M-stage address / write data
//   core_rdata_o        read data to M stage (pass-through of mem_rdata_i)
//   core_stall_o        core request not served this cycle
//   dbg_req_i/we_i      debug request / write enable (held until granted)
//   dbg_addr_i/wdata_i  debug address / write data
//   dbg_gnt_o           debug access performed this cycle
//   dbg_rvalid_o        registered debug read data valid (cycle after grant)
//   dbg_rdata_o         registered debug read data (held until next read)
//   mem_we_o/addr_o     memory write enable / address
//   mem_wdata_o         memory write data
//   mem_rdata_i         memory read data (combinational read)
//   conflict_cnt_o      saturating count of cycles with both requesters active
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // core (M stage) side
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [XLEN-1:0]  core_addr_i,
  input  logic [XLEN-1:0]  core_wdata_i,
  output logic [XLEN-1:0]  core_rdata_o,
  output logic             core_stall_o,
  // debug side
  input  logic             dbg_req_i,
  input  logic             dbg_we_i,
  input  logic [XLEN-1:0]  dbg_addr_i,
  input  logic [XLEN-1:0]  dbg_wdata_i,
  output logic             dbg_gnt_o,
  output logic             dbg_rvalid_o,
  output logic [XLEN-1:0]  dbg_rdata_o,
  // memory side
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  // statistics
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    CORE_PRI  = 1'b0,
    DBG_FORCE = 1'b1
  } state_e;

  state_e            state_q,        state_d;
  logic [WAIT_W-1:0] wait_q,         wait_d;
  logic              dbg_rvalid_q,   dbg_rvalid_d;
  logic [XLEN-1:0]   dbg_rdata_q,    dbg_rdata_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              force_s;
  logic              gnt_core_s;
  logic              gnt_dbg_s;

  // Grant decision: core wins unless the FSM is forcing a pending debug access.
  always_comb begin
    force_s    = (state_q == DBG_FORCE);
    gnt_dbg_s  = dbg_req_i & (~core_req_i | force_s);
    gnt_core_s = core_req_i & ~(dbg_req_i & force_s);
  end

  // Memory port mux: debug fields only when debug is granted, core otherwise.
  always_comb begin
    mem_addr_o  = core_addr_i;
    mem_wdata_o = core_wdata_i;
    if (gnt_dbg_s) begin
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end else begin
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end
    // An ungranted write never reaches memory.
    mem_we_o = (gnt_core_s & core_we_i) | (gnt_dbg_s & dbg_we_i);
  end

  // Starvation counter: counts consecutive denied debug cycles, saturating.
  always_comb begin
    wait_d = wait_q;
    if (dbg_req_i && !gnt_dbg_s) begin
      if (wait_q == WAIT_MAX) begin
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + WAIT_ONE;
      end
    end else begin
      // a grant or a withdrawn request restarts the count
      wait_d = '0;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE_PRI: begin
        // Switch on the next-state counter value so that DBG_FORCE is active
        // in the same cycle the registered counter holds MAX_WAIT; the forced
        // grant then lands right after the MAX_WAIT-th denied cycle.
        if (wait_d == WAIT_MAX) begin
          state_d = DBG_FORCE;
        end else begin
          state_d = CORE_PRI;
        end
      end
      DBG_FORCE: begin
        // With a request present the grant is unconditional here, so this
        // state lasts exactly one debug access (or ends on withdrawal).
        if (gnt_dbg_s || !dbg_req_i) begin
          state_d = CORE_PRI;
        end else begin
          state_d = DBG_FORCE;
        end
      end
      default: begin
        state_d = CORE_PRI;
      end
    endcase
  end

  // Debug read return and conflict statistics next-state values.
  always_comb begin
    dbg_rvalid_d = gnt_dbg_s & ~dbg_we_i;
    if (dbg_rvalid_d) begin
      dbg_rdata_d = mem_rdata_i;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end

    if (core_req_i && dbg_req_i && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_ONE;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State, counters and registered outputs; reset drops any in-flight read return.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= CORE_PRI;
      wait_q         <= '0;
      dbg_rvalid_q   <= 1'b0;
      dbg_rdata_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      dbg_rvalid_q   <= dbg_rvalid_d;
      dbg_rdata_q    <= dbg_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign dbg_gnt_o      = gnt_dbg_s;
  assign core_stall_o   = core_req_i & gnt_dbg_s;
  assign core_rdata_o   = mem_rdata_i;
  assign dbg_rvalid_o   = dbg_rvalid_q;
  assign dbg_rdata_o    = dbg_rdata_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter (MAX_WAIT=4, CNT_W=4). The driver sets
// inputs just after each rising edge and queues the hand-computed expected
// outputs for that cycle; read returns are queued with the cycle they are due.
// A monitor on the falling edge pops and compares. The memory is modelled as
// a fixed function of the address.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             core_req, core_we;
  logic [XLEN-1:0]  core_addr, core_wdata, core_rdata;
  logic             core_stall;
  logic             dbg_req, dbg_we;
  logic [XLEN-1:0]  dbg_addr, dbg_wdata;
  logic             dbg_gnt, dbg_rvalid;
  logic [XLEN-1:0]  dbg_rdata;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  // Memory contents: 0x40 holds 0xDEADBEEF, everything else a tagged address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    else                    return {a[15:0], 16'hC0DE};
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  dmem_port_arbiter #(
    .XLEN     (XLEN),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .core_req_i     (core_req),
    .core_we_i      (core_we),
    .core_addr_i    (core_addr),
    .core_wdata_i   (core_wdata),
    .core_rdata_o   (core_rdata),
    .core_stall_o   (core_stall),
    .dbg_req_i      (dbg_req),
    .dbg_we_i       (dbg_we),
    .dbg_addr_i     (dbg_addr),
    .dbg_wdata_i    (dbg_wdata),
    .dbg_gnt_o      (dbg_gnt),
    .dbg_rvalid_o   (dbg_rvalid),
    .dbg_rdata_o    (dbg_rdata),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .conflict_cnt_o (conflict_cnt)
  );

  // Debug requester must hold its fields while waiting (withdrawal is legal).
  property p_dbg_hold;
    @(posedge clk) disable iff (rst)
      (dbg_req && !dbg_gnt) |=>
        (!dbg_req || ($stable(dbg_we) && $stable(dbg_addr) && $stable(dbg_wdata)));
  endproperty
  a_dbg_hold: assert property (p_dbg_hold)
    else $error("FAIL dbg_hold: debug fields changed while waiting for grant");

  typedef struct {
    string       name;
    logic        gnt;
    logic        stall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_cnt;
    logic [3:0]  cnt;
    logic        chk_rd;
    logic        rv;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  logic mon_en    = 1'b0;
  exp_t e_m;
  rd_t  r_m;
  logic rd_due;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Monitor: compare the queued per-cycle expectation and any due read return.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e_m = exp_q.pop_front();
        chk({e_m.name, ".gnt"},   {31'b0, dbg_gnt},    {31'b0, e_m.gnt});
        chk({e_m.name, ".stall"}, {31'b0, core_stall}, {31'b0, e_m.stall});
        chk({e_m.name, ".we"},    {31'b0, mem_we},     {31'b0, e_m.we});
        chk({e_m.name, ".addr"},  mem_addr,            e_m.addr);
        chk({e_m.name, ".wdata"}, mem_wdata,           e_m.wdata);
        chk({e_m.name, ".core_rdata"}, core_rdata,     mem_word(e_m.addr));
        if (e_m.chk_cnt)
          chk({e_m.name, ".cnt"}, {28'b0, conflict_cnt}, {28'b0, e_m.cnt});
        if (e_m.chk_rd) begin
          chk({e_m.name, ".rvalid"}, {31'b0, dbg_rvalid}, {31'b0, e_m.rv});
          chk({e_m.name, ".rdata"},  dbg_rdata,           e_m.rd);
        end
      end
      rd_due = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, rd_due});
      if (rd_due) begin
        r_m = rd_q.pop_front();
        chk("dbg_rdata", dbg_rdata, r_m.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  task automatic expect_cyc(input string nm, input logic gnt, input logic stall,
                            input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata,
                            input logic chk_cnt = 1'b0, input logic [3:0] cnt = 4'h0,
                            input logic chk_rd = 1'b0, input logic rv = 1'b0,
                            input logic [31:0] rd = 32'h0);
    exp_t e;
    e.name = nm; e.gnt = gnt; e.stall = stall; e.we = we; e.addr = addr;
    e.wdata = wdata; e.chk_cnt = chk_cnt; e.cnt = cnt; e.chk_rd = chk_rd;
    e.rv = rv; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic expect_read(input logic [31:0] d);
    rd_t r;
    r.data = d;
    r.due  = cyc + 1;
    rd_q.push_back(r);
  endtask

  task automatic do_reset();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hard stop in case the run never reaches its summary.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int   t5_cnt [9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
    logic g;

    do_reset();
    mon_en = 1'b1;

    // Reset state with idle inputs.
    expect_cyc("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 32'h0);
    tick();

    // T1: debug read alone, then debug write alone.
    set_core(1'b0, 1'b0, 32'h100, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h40, 32'h0);
    expect_cyc("t1_rd_gnt", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 4'h0);
    expect_read(32'hDEAD_BEEF);
    tick();
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    expect_cyc("t1_rd_ret", 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 4'h0,
               1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    set_dbg(1'b1, 1'b1, 32'h48, 32'h5555_AAAA);
    expect_cyc("t1_wr", 1'b1, 1'b0, 1'b1, 32'h48, 32'h5555_AAAA, 1'b0, 4'h0,
               1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();

    // T2: core alone, write then read.
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    set_core(1'b1, 1'b1, 32'h10, 32'hCAFE_0001);
    expect_cyc("t2_wr", 1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFE_0001);
    tick();
    set_core(1'b1, 1'b0, 32'h40, 32'h0);
    expect_cyc("t2_rd", 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    tick();

    // T3: starvation bound, forced grants in cycles 4 and 9.
    do_reset();
    set_core(1'b1, 1'b0, 32'h200, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c < 10; c++) begin
      g = (c == 4) || (c == 9);
      expect_cyc($sformatf("t3_c%0d", c), g, g, 1'b0, g ? 32'h40 : 32'h200, 32'h0,
                 1'b1, 4'(c));
      if (g) expect_read(32'hDEAD_BEEF);
      tick();
    end
    set_core(1'b0, 1'b0, 32'h200, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    expect_cyc("t3_idle", 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 4'd10);
    tick();

    // T4: conflicting writes to 0x80; core wins until the forced cycle 4.
    do_reset();
    set_core(1'b1, 1'b1, 32'h80, 32'h1111_1111);
    set_dbg(1'b1, 1'b1, 32'h80, 32'h2222_2222);
    for (int c = 0; c < 5; c++) begin
      g = (c == 4);
      expect_cyc($sformatf("t4_c%0d", c), g, g, 1'b1, 32'h80,
                 g ? 32'h2222_2222 : 32'h1111_1111, 1'b1, 4'(c));
      tick();
    end
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    expect_cyc("t4_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5);
    tick();

    // T5: 3 denied, withdraw 1 cycle, then 4 more denied before the grant.
    do_reset();
    set_core(1'b1, 1'b0, 32'h300, 32'h0);
    for (int c = 0; c < 9; c++) begin
      if (c == 3) set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      else        set_dbg(1'b1, 1'b0, 32'h44, 32'h0);
      g = (c == 8);
      expect_cyc($sformatf("t5_c%0d", c), g, g, 1'b0, g ? 32'h44 : 32'h300, 32'h0,
                 1'b1, 4'(t5_cnt[c]));
      if (g) expect_read(32'h0044_C0DE);
      tick();
    end
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    expect_cyc("t5_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd8);
    tick();

    // T6: forced read granted in cycle 4 with reset at the following edge.
    set_core(1'b1, 1'b0, 32'h300, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c < 4; c++) begin
      expect_cyc($sformatf("t6_c%0d", c), 1'b0, 1'b0, 1'b0, 32'h300, 32'h0,
                 1'b1, 4'(8 + c));
      tick();
    end
    rst = 1'b1;
    expect_cyc("t6_gnt", 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 4'd12);
    tick();
    rst = 1'b0;
    expect_cyc("t6_after_rst", 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 4'd0,
               1'b1, 1'b0, 32'h0);
    tick();

    // T7: 20 conflict cycles saturate the 4-bit counter.
    do_reset();
    set_core(1'b1, 1'b0, 32'h300, 32'h0);
    set_dbg(1'b1, 1'b1, 32'h84, 32'h3333_3333);
    for (int c = 0; c < 20; c++) begin
      g = ((c % 5) == 4);
      expect_cyc($sformatf("t7_c%0d", c), g, g, g, g ? 32'h84 : 32'h300,
                 g ? 32'h3333_3333 : 32'h0, 1'b1, 4'((c < 15) ? c : 15));
      tick();
    end
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    expect_cyc("t7_sat", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'hF);
    tick();

    tick();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
